// File: rtl/exec_pkg.sv
// Shared types for the LEGv8 execute stage: ALU opcodes, FSM states and the
// branch-offset shift.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_NOR   = 4'b1100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SHIFT_BR = 2;

endpackage

// File: rtl/execute_mc_if.sv
// Operand/control handshake into the execute stage and result handshake out of it.
interface execute_mc_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] PCBranch_M;
    logic [N-1:0] aluResult_M;
    logic [N-1:0] writeData_M;
    logic         zero_M;

    modport master (
        output in_valid, AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E, out_ready,
        input  in_ready, out_valid, PCBranch_M, aluResult_M, writeData_M, zero_M
    );

    modport slave (
        input  in_valid, AluSrc, AluControl, PC_E, signImm_E, readData1_E, readData2_E, out_ready,
        output in_ready, out_valid, PCBranch_M, aluResult_M, writeData_M, zero_M
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, N clocks per product.
// product/done are combinational so the final partial sum is usable on the last edge.
module mul_iter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         done,
    output logic [N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [N-1:0]  acc_r;
    logic [N-1:0]  acc_next_s;
    logic [CW-1:0] cnt_r;
    logic          run_r;

    // Partial sum after the current iteration; a_r already holds A<<counter.
    always_comb begin
        acc_next_s = acc_r;
        if (b_r[0]) begin
            acc_next_s = acc_r + a_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign done    = run_r && (cnt_r == CW'(N - 1));
    assign product = acc_next_s;

    // Operand shifters, accumulator and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r   <= {N{1'b0}};
            b_r   <= {N{1'b0}};
            acc_r <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
            run_r <= 1'b0;
        end else if (flush) begin
            cnt_r <= {CW{1'b0}};
            run_r <= 1'b0;
        end else if (start) begin
            a_r   <= A;
            b_r   <= B;
            acc_r <= {N{1'b0}};
            cnt_r <= {CW{1'b0}};
            run_r <= 1'b1;
        end else if (run_r) begin
            acc_r <= acc_next_s;
            a_r   <= {a_r[N-2:0], 1'b0};
            b_r   <= {1'b0, b_r[N-1:1]};
            cnt_r <= done ? {CW{1'b0}} : cnt_r + CW'(1);
            run_r <= !done;
        end
    end

endmodule

// File: rtl/execute_mc.sv
// LEGv8 execute stage between ID/EX and EX/MEM: single-cycle ALU, branch target,
// iterative multiply, valid/ready flow control with registered outputs and flush.
module execute_mc
    import exec_pkg::*;
#(
    parameter int N      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    output logic          busy,
    execute_mc_if.slave   bus
);
    state_t       state_r;
    state_t       state_next_s;
    alu_op_t      alu_op_s;
    logic [N-1:0] b_op_s;
    logic [N-1:0] alu_res_s;
    logic         is_mul_s;
    logic         in_ready_s;
    logic         accept_s;
    logic         mul_start_s;
    logic         mul_done_s;
    logic [N-1:0] mul_prod_s;
    logic         out_valid_r;
    logic [N-1:0] pcb_r;
    logic [N-1:0] alu_r;
    logic [N-1:0] wd_r;
    logic         zero_r;

    assign alu_op_s = alu_op_t'(bus.AluControl);
    assign b_op_s   = bus.AluSrc ? bus.signImm_E : bus.readData2_E;
    assign is_mul_s = MUL_EN && (alu_op_s == OP_MUL);

    // Single-cycle ALU; MUL and unknown codes yield zero here.
    always_comb begin
        alu_res_s = {N{1'b0}};
        case (alu_op_s)
            OP_AND:   alu_res_s = bus.readData1_E & b_op_s;
            OP_OR:    alu_res_s = bus.readData1_E | b_op_s;
            OP_ADD:   alu_res_s = bus.readData1_E + b_op_s;
            OP_SUB:   alu_res_s = bus.readData1_E - b_op_s;
            OP_PASSB: alu_res_s = b_op_s;
            OP_NOR:   alu_res_s = ~(bus.readData1_E | b_op_s);
            default:  alu_res_s = {N{1'b0}};
        endcase
    end

    mul_iter #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .start   (mul_start_s),
        .A       (bus.readData1_E),
        .B       (b_op_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; flush wins over every other condition.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = (accept_s && is_mul_s) ? MUL : IDLE;
                MUL:     state_next_s = mul_done_s ? DONE : MUL;
                DONE:    state_next_s = bus.out_ready ? IDLE : DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FSM outputs: in_ready depends only on state and downstream, never on in_valid.
    always_comb begin
        in_ready_s  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
        busy        = (state_r != IDLE);
        accept_s    = bus.in_valid && in_ready_s && !flush;
        mul_start_s = accept_s && is_mul_s;
    end

    // Result valid flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= !is_mul_s;
        end else if ((state_r == MUL) && mul_done_s) begin
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Result data; branch target and store data are captured at accept even for MUL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcb_r  <= {N{1'b0}};
            alu_r  <= {N{1'b0}};
            wd_r   <= {N{1'b0}};
            zero_r <= 1'b0;
        end else if (accept_s) begin
            pcb_r <= bus.PC_E + (bus.signImm_E << SHIFT_BR);
            wd_r  <= bus.readData2_E;
            if (!is_mul_s) begin
                alu_r  <= alu_res_s;
                zero_r <= (alu_res_s == {N{1'b0}});
            end
        end else if ((state_r == MUL) && mul_done_s && !flush) begin
            alu_r  <= mul_prod_s;
            zero_r <= (mul_prod_s == {N{1'b0}});
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.PCBranch_M  = pcb_r;
    assign bus.aluResult_M = alu_r;
    assign bus.writeData_M = wd_r;
    assign bus.zero_M      = zero_r;

endmodule

// File: tb/tb_execute_mc.sv
// Scoreboard bench for execute_mc (N=64, MUL_EN=1): expected results are queued
// at drive time and compared on every output transfer, plus directed timing checks.
module tb_execute_mc;
    localparam int N = 64;

    typedef struct {
        logic [N-1:0] alu;
        logic [N-1:0] pcb;
        logic [N-1:0] wd;
        logic         z;
    } exp_t;

    logic clk;
    logic reset;
    logic flush;
    logic busy;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    execute_mc_if #(.N(N)) bus ();

    execute_mc #(.N(N), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            4'b1100: return ~(a | b);
            4'b1000: return a * b;
            default: return {N{1'b0}};
        endcase
    endfunction

    task automatic set_inputs(input logic [3:0] op, input logic src, input logic [N-1:0] a,
                              input logic [N-1:0] rd2, input logic [N-1:0] imm,
                              input logic [N-1:0] pc, input bit push);
        logic [N-1:0] b;
        logic [N-1:0] r;
        exp_t e;
        bus.AluControl  = op;
        bus.AluSrc      = src;
        bus.readData1_E = a;
        bus.readData2_E = rd2;
        bus.signImm_E   = imm;
        bus.PC_E        = pc;
        bus.in_valid    = 1'b1;
        if (push) begin
            b     = src ? imm : rd2;
            r     = model(op, a, b);
            e.alu = r;
            e.pcb = pc + (imm << 2);
            e.wd  = rd2;
            e.z   = (r == {N{1'b0}});
            sb.push_back(e);
        end
    endtask

    // Present a transaction and return #1 after the edge that accepted it.
    task automatic drive(input logic [3:0] op, input logic src, input logic [N-1:0] a,
                         input logic [N-1:0] rd2, input logic [N-1:0] imm,
                         input logic [N-1:0] pc, input bit push);
        bit got;
        set_inputs(op, src, a, rd2, imm, pc, push);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        if (!got) check("accept_timeout", {N{1'b0}}, {{(N-1){1'b0}}, 1'b1});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", N'(sb.size()), {N{1'b0}});
    endtask

    // Scoreboard monitor: compare every completed output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {{(N-1){1'b0}}, 1'b1}, {N{1'b0}});
            end else begin
                e = sb.pop_front();
                check("sb_alu", bus.aluResult_M, e.alu);
                check("sb_pcb", bus.PCBranch_M, e.pcb);
                check("sb_wd", bus.writeData_M, e.wd);
                check("sb_zero", N'(bus.zero_M), N'(e.z));
            end
        end
    end

    initial begin
        logic [3:0]   ops [8];
        logic [N-1:0] a_v;
        logic [N-1:0] b_v;
        int           bad;
        ops = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0011, 4'b1111, 4'b0010, 4'b0110};
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.AluSrc = 1'b0;
        bus.AluControl = 4'b0000;
        bus.PC_E = '0;
        bus.signImm_E = '0;
        bus.readData1_E = '0;
        bus.readData2_E = '0;

        #3;
        check("rst_out_valid", N'(bus.out_valid), 64'd0);
        check("rst_busy", N'(busy), 64'd0);
        check("rst_alu", bus.aluResult_M, 64'd0);
        check("rst_pcb", bus.PCBranch_M, 64'd0);
        check("rst_wd", bus.writeData_M, 64'd0);
        check("rst_zero", N'(bus.zero_M), 64'd0);
        check("rst_in_ready", N'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // ADD with immediate, latency one
        drive(4'b0010, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1000, 1'b1);
        @(negedge clk);
        check("add_valid", N'(bus.out_valid), 64'd1);
        check("add_alu", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
        check("add_zero", N'(bus.zero_M), 64'd0);
        check("add_pcb", bus.PCBranch_M, 64'h0FE0);
        @(posedge clk);
        #1;

        // SUB equal operands
        drive(4'b0110, 1'b0, 64'h1234, 64'h1234, 64'd0, 64'h40, 1'b1);
        @(negedge clk);
        check("sub_alu", bus.aluResult_M, 64'd0);
        check("sub_zero", N'(bus.zero_M), 64'd1);
        check("sub_wd", bus.writeData_M, 64'h1234);
        @(posedge clk);
        #1;

        // MUL 7*6: busy for N cycles, result N edges after accept
        drive(4'b1000, 1'b0, 64'd7, 64'd6, 64'd3, 64'h200, 1'b1);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (bus.out_valid || !busy || bus.in_ready) bad++;
        end
        check("mul_busy_window", N'(bad), 64'd0);
        @(negedge clk);
        check("mul_valid", N'(bus.out_valid), 64'd1);
        check("mul_alu", bus.aluResult_M, 64'd42);
        @(posedge clk);
        #1;

        drive(4'b1000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'd2, 64'h300, 1'b1);
        wait_drain();
        check("mul_wrap_last", bus.aluResult_M, 64'hFFFF_FFFF_FFFF_FFFE);

        // Back-to-back single-cycle ops, including unknown codes
        for (int i = 0; i < 8; i++) begin
            a_v = {$urandom, $urandom};
            b_v = {$urandom, $urandom};
            drive(ops[i], i[0], a_v, b_v, b_v ^ 64'h55, a_v, 1'b1);
        end
        wait_drain();

        // Backpressure after an OR result
        bus.out_ready = 1'b0;
        drive(4'b0001, 1'b0, 64'hF0, 64'h0F, 64'd1, 64'd0, 1'b1);
        set_inputs(4'b0010, 1'b0, 64'd10, 64'd20, 64'd0, 64'h10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", N'(bus.out_valid), 64'd1);
            check("bp_alu", bus.aluResult_M, 64'hFF);
            check("bp_pcb", bus.PCBranch_M, 64'd4);
            check("bp_in_ready", N'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", N'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_alu", bus.aluResult_M, 64'd30);
        @(posedge clk);
        #1;
        wait_drain();

        // Asynchronous reset at MUL iteration 10
        drive(4'b1000, 1'b0, 64'd7, 64'd6, 64'd1, 64'h100, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", N'(bus.out_valid), 64'd0);
        check("arst_busy", N'(busy), 64'd0);
        check("arst_pcb", bus.PCBranch_M, 64'd0);
        check("arst_wd", bus.writeData_M, 64'd0);
        check("arst_alu", bus.aluResult_M, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_in_ready", N'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Flush at MUL iteration 20 with a simultaneous in_valid
        drive(4'b1000, 1'b0, 64'd3, 64'd5, 64'd0, 64'h0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        set_inputs(4'b0010, 1'b0, 64'd3, 64'd4, 64'd0, 64'h0, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", N'(bus.out_valid), 64'd0);
        check("flush_busy", N'(busy), 64'd0);
        check("flush_in_ready", N'(bus.in_ready), 64'd1);
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.out_valid || busy) bad++;
        end
        check("flush_quiet", N'(bad), 64'd0);
        @(posedge clk);
        #1;
        drive(4'b0010, 1'b0, 64'd1, 64'd1, 64'd0, 64'h0, 1'b1);
        @(negedge clk);
        check("post_flush_alu", bus.aluResult_M, 64'd2);
        check("post_flush_valid", N'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised, handshaked execute stage for the pipelined LEGv8 datapath; sits between the ID/EX and EX/MEM boundaries.
- Computes the branch target (PC + imm<<2) and the ALU result, with operand B selected between register and immediate.
- Adds an iterative multi-cycle multiply (shift-add), valid/ready flow control, registered outputs and flush.

Parameters:
- N, 64, datapath width in bits (PC, immediate, operands, results); legal range 8..64.
- MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL treated as an unrecognised code.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and control are valid this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- flush  in  1  synchronous squash of in-flight and held work.
- AluSrc  in  1  0 = B is readData2_E; 1 = B is signImm_E.
- AluControl  in  4  operation code (see Behaviour).
- PC_E  in  N  PC of the instruction.
- signImm_E  in  N  sign-extended immediate.
- readData1_E  in  N  operand A.
- readData2_E  in  N  register operand B and store data.
- out_valid  out  1  registered results are valid.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- PCBranch_M  out  N  PC_E + (signImm_E << 2), truncated to N bits.
- aluResult_M  out  N  ALU or multiply result.
- writeData_M  out  N  readData2_E captured at accept.
- zero_M  out  1  aluResult_M == 0.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A-B), 0111 PASSB, 1100 NOR.
  - 1000 MUL: low N bits of A*B, unsigned; only when MUL_EN=1.
  - Any other code, and MUL when MUL_EN=0: result 0, zero_M=1.
- Arithmetic wraps modulo 2^N; no flags other than zero.
- Reset (reset=0, asynchronous): state IDLE; out_valid=0, busy=0; PCBranch_M, aluResult_M and writeData_M = 0; zero_M=0; iteration counter = 0. Release is synchronous to clk.
- in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, with no path from in_valid.
- FSM states: IDLE, MUL, DONE.
- IDLE, accept of a non-MUL op at edge t:
  - Outputs are loaded and out_valid=1 after edge t (latency 1).
  - The state stays IDLE, so back-to-back accepts are possible when out_ready=1.
- IDLE, accept of MUL at edge t:
  - A, B, PC target and writeData are latched; accumulator cleared; counter = 0; state goes to MUL.
  - out_valid falls after t if the previous result was taken at t.
- MUL:
  - Each edge: if B[counter] is set, accumulator += A<<counter; counter++.
  - After N iterations (edge t+N), aluResult_M/zero_M are loaded, out_valid=1 and the state goes to DONE.
- DONE: the state returns to IDLE at the first edge where out_ready=1; the outputs hold until then.
- Output hold: while out_valid && !out_ready, every output is stable.
- flush=1 at an edge, from any state:
  - out_valid=0, state IDLE, counter=0.
  - Any simultaneous accept is ignored; flush has priority over in_valid and out_ready.
  - Data registers may keep stale values.
- PCBranch_M: the shift drops the top 2 bits of signImm_E before the add; it is computed at accept, including for MUL.
- zero_M is always consistent with the aluResult_M it accompanies.

Decomposition:
- Package exec_pkg holds:
  - typedef enum logic [3:0] alu_op_t, with the opcode values above.
  - typedef enum state_t {IDLE, MUL, DONE}.
  - Constant SHIFT_BR = 2.
- Sub-module mul_iter #(N):
  - Ports: start, A, B, done, product.
  - Contains the bit counter and accumulator; it is the natural split point.
- The single-cycle ALU stays inline as a combinational case on alu_op_t.

Test Plan:
- Reset mid-MUL: assert reset=0 at iteration 10 -> out_valid=0, busy=0, all outputs 0 immediately (async); after release, in_ready=1.
- ADD, N=64, AluSrc=1, A=5, imm=-8, PC=0x1000, out_ready=1 -> next cycle: aluResult_M=0xFFFF_FFFF_FFFF_FFFD, zero_M=0, PCBranch_M=0x0FE0, out_valid=1.
- SUB with A=B=0x1234 and AluSrc=0 -> aluResult_M=0, zero_M=1; writeData_M=0x1234.
- MUL, A=7, B=6 -> in_ready=0 and busy=1 for 64 cycles; out_valid rises exactly 64 edges after accept with aluResult_M=42; also check that 0xFFFF_FFFF_FFFF_FFFF*2 gives 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: out_ready=0 for 5 cycles after an OR result -> outputs stable, in_ready=0; the next accept occurs in the cycle where out_ready=1.
- Flush at MUL iteration 20 with a simultaneous in_valid -> out_valid stays 0, state IDLE, nothing accepted; next ADD 1+1 -> 2 after one cycle.
